// File: rtl/zx_mem_pkg.sv
// Shared types and constants for the ZX Spectrum memory mapper.
// Optional +3 paging is enabled by defining PLUS3_PAGING_EN.
package zx_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PULSE1 = 2'd1,
    ST_PULSE2 = 2'd2,
    ST_HOLD   = 2'd3
  } wr_state_t;

  // Banks hard-wired behind the 4000 and 8000 windows.
  localparam logic [2:0] BANK_4000  = 3'd5;
  localparam logic [2:0] BANK_8000  = 3'd2;

  // Upper three SRAM address bits that select the ROM area.
  localparam logic [2:0] ROM_PREFIX = 3'b010;

  // Port decode: a port hits when (a & mask) == match.
`ifdef PLUS3_PAGING_EN
  localparam logic [15:0] PORT_7FFD_MASK  = 16'hC002;
  localparam logic [15:0] PORT_7FFD_MATCH = 16'h4000;
  localparam logic [15:0] PORT_1FFD_MASK  = 16'hF002;
  localparam logic [15:0] PORT_1FFD_MATCH = 16'h1000;
`else
  localparam logic [15:0] PORT_7FFD_MASK  = 16'h8002;
  localparam logic [15:0] PORT_7FFD_MATCH = 16'h0000;
`endif

  function automatic logic port_hit(input logic [15:0] addr,
                                    input logic [15:0] mask,
                                    input logic [15:0] match);
    return (addr & mask) == match;
  endfunction

endpackage

// File: rtl/zx_bank_map.sv
// Combinational region -> SRAM bank mapping (sa[18:14]).
// With PLUS3_PAGING_EN defined, adds the +3 ROM high bit and special
// all-RAM modes selected by the 1FFD register.
module zx_bank_map
  import zx_mem_pkg::*;
(
  input  logic [1:0] region,   // a[15:14]
  input  logic [2:0] ram_sel,  // 7FFD bank for the C000 window
  input  logic       rom_sel,  // 7FFD ROM select bit
`ifdef PLUS3_PAGING_EN
  input  logic [2:0] p1ffd,
`endif
  output logic [4:0] sa_hi,
  output logic       is_rom
);

`ifdef PLUS3_PAGING_EN
  // Special-mode bank for each 16K region, indexed by p1ffd[2:1].
  function automatic logic [2:0] special_bank(input logic [1:0] mode,
                                              input logic [1:0] reg_idx);
    logic [2:0] bank;
    case (mode)
      2'b00:   bank = {1'b0, reg_idx};
      2'b01:   bank = {1'b1, reg_idx};
      2'b10:   bank = (reg_idx == 2'd3) ? 3'd3 : {1'b1, reg_idx};
      default: begin
        case (reg_idx)
          2'd0:    bank = 3'd4;
          2'd1:    bank = 3'd7;
          2'd2:    bank = 3'd6;
          default: bank = 3'd3;
        endcase
      end
    endcase
    return bank;
  endfunction
`endif

  // Normal 48K/128K map, overridden by +3 special mode when present.
  always_comb begin
    logic rom_hi;
    // NOTE: every output gets a default first so no path can infer a latch.
    sa_hi  = 5'd0;
    is_rom = 1'b0;
`ifdef PLUS3_PAGING_EN
    rom_hi = p1ffd[2];
`else
    rom_hi = 1'b0;
`endif
    case (region)
      2'd0: begin
        is_rom = 1'b1;
        sa_hi  = {ROM_PREFIX, rom_hi, rom_sel};
      end
      2'd1:    sa_hi = {2'b00, BANK_4000};
      2'd2:    sa_hi = {2'b00, BANK_8000};
      default: sa_hi = {2'b00, ram_sel};
    endcase
`ifdef PLUS3_PAGING_EN
    if (p1ffd[0]) begin
      is_rom = 1'b0;
      sa_hi  = {2'b00, special_bank(p1ffd[2:1], region)};
    end
`endif
  end

endmodule

// File: rtl/zx_mem_mapper.sv
// ZX Spectrum 128K memory mapper: 7FFD paging, SRAM strobe generation
// and CPU read-data return. Define PLUS3_PAGING_EN for the +3 1FFD
// register and special paging modes.
// The CPU write-data port is called wdata because "do" is a reserved word.
module zx_mem_mapper
  import zx_mem_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] a,
  input  logic [7:0]  wdata,
  output logic [7:0]  di,
  input  logic        mreq,
  input  logic        iorq,
  input  logic        rd,
  input  logic        wr,
  input  logic        m1,
  input  logic        rfsh,
  output logic [18:0] sa,
  output logic [7:0]  sd_o,
  input  logic [7:0]  sd_i,
  output logic        swe,
  output logic        soe,
  output logic [5:0]  page
);

  logic      mw_q, mr_q, iow_q;
  logic      mw_prev, iow_prev;
  logic      mw_evt, iow_evt;
  logic      is_rom;
  logic [4:0] sa_hi;
  wr_state_t state, state_nxt;

`ifdef PLUS3_PAGING_EN
  logic [2:0] p1ffd;
`endif

  // Register the qualified strobes once and keep the previous value for edge detection.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      mw_q     <= 1'b0;
      mr_q     <= 1'b0;
      iow_q    <= 1'b0;
      mw_prev  <= 1'b0;
      iow_prev <= 1'b0;
    end else begin
      mw_q     <= !mreq && !wr && rfsh;
      mr_q     <= !mreq && !rd && rfsh;
      iow_q    <= !iorq && !wr && m1;
      mw_prev  <= mw_q;
      iow_prev <= iow_q;
    end
  end

  assign mw_evt  = mw_q  && !mw_prev;
  assign iow_evt = iow_q && !iow_prev;

  // Paging registers; the lock bit blocks all further writes until reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      page  <= 6'd0;
`ifdef PLUS3_PAGING_EN
      p1ffd <= 3'd0;
`endif
    end else if (iow_evt && !page[5]) begin
      if (port_hit(a, PORT_7FFD_MASK, PORT_7FFD_MATCH)) begin
        page <= wdata[5:0];
      end
`ifdef PLUS3_PAGING_EN
      else if (port_hit(a, PORT_1FFD_MASK, PORT_1FFD_MATCH)) begin
        p1ffd <= wdata[2:0];
      end
`endif
    end
  end

  zx_bank_map u_bank_map (
    .region  (a[15:14]),
    .ram_sel (page[2:0]),
    .rom_sel (page[4]),
`ifdef PLUS3_PAGING_EN
    .p1ffd   (p1ffd),
`endif
    .sa_hi   (sa_hi),
    .is_rom  (is_rom)
  );

  assign sa = {sa_hi, a[13:0]};

  // Write FSM state register.
  always_ff @(posedge clock) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Write FSM next state: RAM writes get a 2-clock pulse, ROM writes only wait out the cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (mw_evt) state_nxt = is_rom ? ST_HOLD : ST_PULSE1;
      end
      ST_PULSE1: state_nxt = ST_PULSE2;
      ST_PULSE2: state_nxt = ST_HOLD;
      default: begin
        if (!mw_q) state_nxt = ST_IDLE;
      end
    endcase
  end

  // Capture write data at the start of a RAM write pulse.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sd_o <= 8'd0;
    end else if (state == ST_IDLE && mw_evt && !is_rom) begin
      sd_o <= wdata;
    end
  end

  // SRAM strobes and read-data return; soe only in IDLE so swe/soe never overlap.
  always_comb begin
    swe = !(state == ST_PULSE1 || state == ST_PULSE2);
    soe = !(mr_q && state == ST_IDLE);
    di  = mr_q ? sd_i : 8'hFF;
  end

endmodule
